// File: rtl/speriph_plug_arbiter.sv
// Round-robin N-to-1 combiner for peripheral bus slave plugs with an in-order response route FIFO.
// Optional stall counter enabled by defining SPERIPH_ARB_STALL_CNT_EN.
module speriph_plug_arbiter #(
  parameter int NB_PLUGS        = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 5,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NB_PLUGS-1:0]              plug_req_i,
  input  logic [NB_PLUGS*ADDR_WIDTH-1:0]   plug_add_i,
  input  logic [NB_PLUGS-1:0]              plug_wen_i,
  input  logic [NB_PLUGS*DATA_WIDTH-1:0]   plug_wdata_i,
  input  logic [NB_PLUGS*DATA_WIDTH/8-1:0] plug_be_i,
  input  logic [NB_PLUGS*ID_WIDTH-1:0]     plug_id_i,
  output logic [NB_PLUGS-1:0]              plug_gnt_o,
  output logic [NB_PLUGS-1:0]              plug_r_valid_o,
  output logic [NB_PLUGS*DATA_WIDTH-1:0]   plug_r_rdata_o,
  output logic [NB_PLUGS-1:0]              plug_r_opc_o,
  output logic [NB_PLUGS*ID_WIDTH-1:0]     plug_r_id_o,
  output logic                             slv_req_o,
  output logic [ADDR_WIDTH-1:0]            slv_add_o,
  output logic                             slv_wen_o,
  output logic [DATA_WIDTH-1:0]            slv_wdata_o,
  output logic [DATA_WIDTH/8-1:0]          slv_be_o,
  output logic [ID_WIDTH-1:0]              slv_id_o,
  input  logic                             slv_gnt_i,
  input  logic                             slv_r_valid_i,
  input  logic [DATA_WIDTH-1:0]            slv_r_rdata_i,
  input  logic                             slv_r_opc_i,
  input  logic [ID_WIDTH-1:0]              slv_r_id_i,
  output logic                             err_o,
  output logic [15:0]                      stall_cnt_o,
  input  logic                             stall_clr_i
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int PW   = (NB_PLUGS > 1) ? $clog2(NB_PLUGS) : 1;
  localparam int FW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW   = $clog2(MAX_OUTSTANDING + 1);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win;
  logic          found;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [PW-1:0] route_q [MAX_OUTSTANDING];
  logic [FW-1:0] wr_ptr;
  logic [FW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // First pass scans rr_ptr..top, second pass wraps to the lowest requester.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NB_PLUGS; i++) begin
      if (!found && plug_req_i[i] && (PW'(i) >= rr_ptr)) begin
        found = 1'b1;
        win   = PW'(i);
      end
    end
    for (int i = 0; i < NB_PLUGS; i++) begin
      if (!found && plug_req_i[i]) begin
        found = 1'b1;
        win   = PW'(i);
      end
    end
  end

  assign full      = (count == CW'(MAX_OUTSTANDING));
  assign empty     = (count == '0);
  // Request gating uses only the registered count, so r_valid never reaches slv_req_o.
  assign slv_req_o = found & ~full;
  assign push      = slv_req_o & slv_gnt_i;
  assign pop       = slv_r_valid_i & ~empty;

  always_comb begin
    slv_add_o   = '0;
    slv_wen_o   = 1'b0;
    slv_wdata_o = '0;
    slv_be_o    = '0;
    slv_id_o    = '0;
    plug_gnt_o  = '0;
    for (int i = 0; i < NB_PLUGS; i++) begin
      if (slv_req_o && (win == PW'(i))) begin
        slv_add_o     = plug_add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        slv_wen_o     = plug_wen_i[i];
        slv_wdata_o   = plug_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        slv_be_o      = plug_be_i[i*BE_W +: BE_W];
        slv_id_o      = plug_id_i[i*ID_WIDTH +: ID_WIDTH];
        plug_gnt_o[i] = slv_gnt_i;
      end
    end
  end

  always_comb begin
    plug_r_valid_o = '0;
    if (pop) plug_r_valid_o[route_q[rd_ptr]] = 1'b1;
  end

  assign plug_r_rdata_o = {NB_PLUGS{slv_r_rdata_i}};
  assign plug_r_opc_o   = {NB_PLUGS{slv_r_opc_i}};
  assign plug_r_id_o    = {NB_PLUGS{slv_r_id_i}};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_o  <= 1'b0;
    end else begin
      if (push) begin
        rr_ptr <= (win == PW'(NB_PLUGS - 1)) ? '0 : win + PW'(1);
        wr_ptr <= (wr_ptr == FW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + FW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == FW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + FW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
      // A response with nothing outstanding (even if a push lands this cycle) is unroutable.
      if (slv_r_valid_i && empty) err_o <= 1'b1;
    end
  end

  // Route entries are only read while counted valid, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (push) route_q[wr_ptr] <= win;
  end

`ifdef SPERIPH_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
    end else if (stall_clr_i) begin
      stall_cnt <= '0;
    end else if ((|plug_req_i) && !(|plug_gnt_o) && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`else
  logic unused_stall_clr;

  assign unused_stall_clr = stall_clr_i;
  assign stall_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_speriph_plug_arbiter.sv
// Directed bench for speriph_plug_arbiter (3 plugs, 2 outstanding); stall expectations follow
// SPERIPH_ARB_STALL_CNT_EN.
module tb_speriph_plug_arbiter;

  localparam int NB = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int IW = 5;
  localparam int MO = 2;
`ifdef SPERIPH_ARB_STALL_CNT_EN
  localparam logic STALL_ON = 1'b1;
`else
  localparam logic STALL_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NB-1:0]     plug_req_i;
  logic [NB*AW-1:0]  plug_add_i;
  logic [NB-1:0]     plug_wen_i;
  logic [NB*DW-1:0]  plug_wdata_i;
  logic [NB*BW-1:0]  plug_be_i;
  logic [NB*IW-1:0]  plug_id_i;
  logic [NB-1:0]     plug_gnt_o;
  logic [NB-1:0]     plug_r_valid_o;
  logic [NB*DW-1:0]  plug_r_rdata_o;
  logic [NB-1:0]     plug_r_opc_o;
  logic [NB*IW-1:0]  plug_r_id_o;
  logic              slv_req_o;
  logic [AW-1:0]     slv_add_o;
  logic              slv_wen_o;
  logic [DW-1:0]     slv_wdata_o;
  logic [BW-1:0]     slv_be_o;
  logic [IW-1:0]     slv_id_o;
  logic              slv_gnt_i;
  logic              slv_r_valid_i;
  logic [DW-1:0]     slv_r_rdata_i;
  logic              slv_r_opc_i;
  logic [IW-1:0]     slv_r_id_i;
  logic              err_o;
  logic [15:0]       stall_cnt_o;
  logic              stall_clr_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  speriph_plug_arbiter #(
    .NB_PLUGS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .plug_req_i(plug_req_i), .plug_add_i(plug_add_i), .plug_wen_i(plug_wen_i),
    .plug_wdata_i(plug_wdata_i), .plug_be_i(plug_be_i), .plug_id_i(plug_id_i),
    .plug_gnt_o(plug_gnt_o), .plug_r_valid_o(plug_r_valid_o), .plug_r_rdata_o(plug_r_rdata_o),
    .plug_r_opc_o(plug_r_opc_o), .plug_r_id_o(plug_r_id_o),
    .slv_req_o(slv_req_o), .slv_add_o(slv_add_o), .slv_wen_o(slv_wen_o),
    .slv_wdata_o(slv_wdata_o), .slv_be_o(slv_be_o), .slv_id_o(slv_id_o),
    .slv_gnt_i(slv_gnt_i), .slv_r_valid_i(slv_r_valid_i), .slv_r_rdata_i(slv_r_rdata_i),
    .slv_r_opc_i(slv_r_opc_i), .slv_r_id_i(slv_r_id_i),
    .err_o(err_o), .stall_cnt_o(stall_cnt_o), .stall_clr_i(stall_clr_i)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_plug(input int p, input logic [AW-1:0] add, input logic [IW-1:0] id);
    plug_add_i[p*AW +: AW]   = add;
    plug_id_i[p*IW +: IW]    = id;
    plug_wdata_i[p*DW +: DW] = 32'hD000_0000 | add;
    plug_be_i[p*BW +: BW]    = BW'(p + 1);
    plug_wen_i[p]            = p[0];
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    plug_req_i = '0; plug_add_i = '0; plug_wen_i = '0; plug_wdata_i = '0;
    plug_be_i = '0; plug_id_i = '0;
    slv_gnt_i = 1'b0; slv_r_valid_i = 1'b0; slv_r_rdata_i = '0; slv_r_opc_i = 1'b0;
    slv_r_id_i = '0; stall_clr_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_val("rst_gnt", 64'(plug_gnt_o), 64'h0);
    check_val("rst_req", 64'(slv_req_o), 64'h0);
    check_val("rst_add", 64'(slv_add_o), 64'h0);
    check_val("rst_rvalid", 64'(plug_r_valid_o), 64'h0);
    check_val("rst_err", 64'(err_o), 64'h0);
    check_val("rst_stall", 64'(stall_cnt_o), 64'h0);
    rst_i = 1'b0;
    cyc();

    // single requester on plug 2
    set_plug(2, 32'h10, 5'd5);
    plug_req_i = 3'b100; slv_gnt_i = 1'b1; #1;
    check_val("single_req", 64'(slv_req_o), 64'h1);
    check_val("single_add", 64'(slv_add_o), 64'h10);
    check_val("single_id", 64'(slv_id_o), 64'h5);
    check_val("single_wdata", 64'(slv_wdata_o), 64'hD000_0010);
    check_val("single_be", 64'(slv_be_o), 64'h3);
    check_val("single_wen", 64'(slv_wen_o), 64'h0);
    check_val("single_gnt", 64'(plug_gnt_o), 64'h4);
    cyc();
    plug_req_i = '0; slv_r_valid_i = 1'b1; slv_r_rdata_i = 32'hCAFE_0001;
    slv_r_opc_i = 1'b1; slv_r_id_i = 5'd5; #1;
    check_val("single_rvalid", 64'(plug_r_valid_o), 64'h4);
    check_val("single_rdata0", 64'(plug_r_rdata_o[0 +: DW]), 64'hCAFE_0001);
    check_val("single_rdata2", 64'(plug_r_rdata_o[2*DW +: DW]), 64'hCAFE_0001);
    check_val("single_opc", 64'(plug_r_opc_o), 64'h7);
    check_val("single_rid1", 64'(plug_r_id_o[IW +: IW]), 64'h5);
    check_val("single_idle_req", 64'(slv_req_o), 64'h0);
    cyc();
    slv_r_valid_i = 1'b0; slv_r_opc_i = 1'b0;

    // round-robin fairness with responses one cycle behind
    for (int p = 0; p < NB; p++) set_plug(p, AW'(32'h100 + p), IW'(p + 1));
    plug_req_i = 3'b111;
    for (int k = 0; k <= 6; k++) begin
      if (k == 6) plug_req_i = '0;
      slv_r_valid_i = (k > 0);
      slv_r_rdata_i = DW'(k);
      #1;
      if (k == 0) check_val("rr_add0", 64'(slv_add_o), 64'h100);
      if (k < 6) check_val($sformatf("rr_gnt%0d", k), 64'(plug_gnt_o), 64'(1 << (k % 3)));
      if (k > 0) check_val($sformatf("rr_rvalid%0d", k), 64'(plug_r_valid_o), 64'(1 << ((k - 1) % 3)));
      cyc();
    end
    slv_r_valid_i = 1'b0;

    // route FIFO full, then full + pop in the same cycle
    plug_req_i = 3'b001; #1;
    check_val("full_gnt_a", 64'(plug_gnt_o), 64'h1);
    cyc(); #1;
    check_val("full_gnt_b", 64'(plug_gnt_o), 64'h1);
    cyc(); #1;
    check_val("full_req", 64'(slv_req_o), 64'h0);
    check_val("full_gnt", 64'(plug_gnt_o), 64'h0);
    check_val("full_add", 64'(slv_add_o), 64'h0);
    cyc();
    slv_r_valid_i = 1'b1; #1;
    check_val("full_pop_req", 64'(slv_req_o), 64'h0);
    check_val("full_pop_rvalid", 64'(plug_r_valid_o), 64'h1);
    cyc();
    slv_r_valid_i = 1'b0; #1;
    check_val("resume_req", 64'(slv_req_o), 64'h1);
    check_val("resume_gnt", 64'(plug_gnt_o), 64'h1);
    cyc();
    check_val("full_stall", 64'(stall_cnt_o), STALL_ON ? 64'd2 : 64'd0);
    plug_req_i = '0; slv_r_valid_i = 1'b1; #1;
    check_val("drain_a", 64'(plug_r_valid_o), 64'h1);
    cyc(); #1;
    check_val("drain_b", 64'(plug_r_valid_o), 64'h1);
    cyc();
    slv_r_valid_i = 1'b0;

    // stall counter under slave backpressure, then clear with increment pending
    stall_clr_i = 1'b1;
    cyc();
    stall_clr_i = 1'b0;
    check_val("stall_clr0", 64'(stall_cnt_o), 64'h0);
    plug_req_i = 3'b001; slv_gnt_i = 1'b0; #1;
    check_val("bp_req", 64'(slv_req_o), 64'h1);
    check_val("bp_gnt", 64'(plug_gnt_o), 64'h0);
    repeat (5) cyc();
    check_val("stall_5", 64'(stall_cnt_o), STALL_ON ? 64'd5 : 64'd0);
    stall_clr_i = 1'b1;
    cyc();
    stall_clr_i = 1'b0;
    check_val("stall_clr_prio", 64'(stall_cnt_o), 64'h0);
    plug_req_i = '0;

    // response while empty but a push lands the same cycle: unrouted
    plug_req_i = 3'b010; slv_gnt_i = 1'b1; slv_r_valid_i = 1'b1; #1;
    check_val("epr_gnt", 64'(plug_gnt_o), 64'h2);
    check_val("epr_rvalid", 64'(plug_r_valid_o), 64'h0);
    cyc();
    check_val("epr_err", 64'(err_o), 64'h1);
    plug_req_i = '0; #1;
    check_val("epr_route", 64'(plug_r_valid_o), 64'h2);
    cyc(); #1;
    check_val("spur_rvalid", 64'(plug_r_valid_o), 64'h0);
    cyc();
    slv_r_valid_i = 1'b0;
    check_val("err_sticky", 64'(err_o), 64'h1);

    // reset with one outstanding; rr_ptr was 2 before reset
    plug_req_i = 3'b010; #1;
    check_val("pre_rst_gnt", 64'(plug_gnt_o), 64'h2);
    cyc();
    plug_req_i = '0; slv_gnt_i = 1'b0;
    rst_i = 1'b1; #1;
    check_val("mid_rst_err", 64'(err_o), 64'h0);
    cyc();
    rst_i = 1'b0;
    plug_req_i = 3'b111; #1;
    check_val("post_rst_add", 64'(slv_add_o), 64'h100);
    check_val("post_rst_req", 64'(slv_req_o), 64'h1);
    plug_req_i = '0; slv_r_valid_i = 1'b1; #1;
    check_val("late_rvalid", 64'(plug_r_valid_o), 64'h0);
    cyc();
    slv_r_valid_i = 1'b0;
    check_val("late_err", 64'(err_o), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
